bus_requester: RTL

- Per-cache initiator side of the shared snooping bus; one instance per cache (NUM_CACHE instances).
- Buffers coherence commands from the cache controller and raises req to the round-robin bus arbiter.
- On gnt, drives one bus transaction and holds busy high until the transaction completes, which blocks all other grants.
- Returns the completion (fill data, shared flag) to the cache controller.

---
 rtl/bus_requester_if.sv | 49 ++++
 rtl/bus_requester.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_requester_if.sv
// Controller, arbiter and snooping-bus signals of one bus requester.
// master is the requester's view; slave is the environment's view.
interface bus_requester_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LINE_WIDTH-1:0] cmd_wdata;

   logic                  resp_valid;
   logic [LINE_WIDTH-1:0] resp_rdata;
   logic                  resp_shared;
   logic                  err;

   logic                  req;
   logic                  gnt;
   logic                  busy;

   logic                  bus_valid;
   logic [1:0]            bus_op;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [LINE_WIDTH-1:0] bus_wdata;
   logic                  bus_ack;
   logic [LINE_WIDTH-1:0] bus_rdata;
   logic                  bus_shared;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
      output cmd_ready,
      output resp_valid, resp_rdata, resp_shared, err,
      output req, busy,
      input  gnt,
      output bus_valid, bus_op, bus_addr, bus_wdata,
      input  bus_ack, bus_rdata, bus_shared
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  resp_valid, resp_rdata, resp_shared, err,
      input  req, busy,
      output gnt,
      input  bus_valid, bus_op, bus_addr, bus_wdata,
      output bus_ack, bus_rdata, bus_shared
   );
endinterface

// File: rtl/bus_requester.sv
// Per-cache initiator on the shared snooping bus: queues controller commands,
// requests the bus, runs one transaction at a time and returns the completion.
module bus_requester #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int QUEUE_DEPTH = 2,
   parameter int TIMEOUT     = 255
) (
   input logic             clk,
   input logic             rst,
   bus_requester_if.master bif
);
   // state | meaning
   // IDLE  | waiting for a queued command
   // REQ   | transaction loaded, requesting the bus
   // ISSUE | command phase on the bus, exactly one cycle
   // WAIT  | waiting for bus_ack or timeout
   // RESP  | completion presented to the controller, one cycle

   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(QUEUE_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [1:0]            fifo_op    [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr  [QUEUE_DEPTH];
   logic [LINE_WIDTH-1:0] fifo_wdata [QUEUE_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop, full, empty;

   logic [1:0]            txn_op_q, txn_op_d;
   logic [ADDR_WIDTH-1:0] txn_addr_q, txn_addr_d;
   logic [LINE_WIDTH-1:0] txn_wdata_q, txn_wdata_d;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
   logic                  shared_q, shared_d;
   logic                  err_q, err_d;

   logic on_bus, in_resp;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = bif.cmd_valid && !full;
   assign pop   = (state_q == S_IDLE) && !empty;

   // Write data is only meaningful for WriteBack, so other ops store zero.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr_q]    <= bif.cmd_op;
         fifo_addr[wr_ptr_q]  <= bif.cmd_addr;
         fifo_wdata[wr_ptr_q] <= (bif.cmd_op == 2'd3) ? bif.cmd_wdata : '0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      txn_op_d    = txn_op_q;
      txn_addr_d  = txn_addr_q;
      txn_wdata_d = txn_wdata_q;
      rdata_d     = rdata_q;
      shared_d    = shared_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d     = S_REQ;
               txn_op_d    = fifo_op[rd_ptr_q];
               txn_addr_d  = fifo_addr[rd_ptr_q];
               txn_wdata_d = fifo_wdata[rd_ptr_q];
            end
         end
         S_REQ: begin
            if (bif.gnt) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
         end
         S_WAIT: begin
            // cnt_q counts cycles since ISSUE; an ack on the last cycle still wins.
            if (bif.bus_ack) begin
               state_d  = S_RESP;
               rdata_d  = txn_op_q[1] ? '0 : bif.bus_rdata;
               shared_d = bif.bus_shared;
               err_d    = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_RESP;
               rdata_d  = '0;
               shared_d = 1'b0;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         txn_op_q    <= '0;
         txn_addr_q  <= '0;
         txn_wdata_q <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         shared_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         txn_op_q    <= txn_op_d;
         txn_addr_q  <= txn_addr_d;
         txn_wdata_q <= txn_wdata_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         shared_q    <= shared_d;
         err_q       <= err_d;
      end
   end

   // All outputs decode registered state, so reset clears them asynchronously.
   assign on_bus  = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign in_resp = (state_q == S_RESP);

   assign bif.cmd_ready   = !full;
   assign bif.req         = (state_q == S_REQ);
   assign bif.busy        = on_bus;
   assign bif.bus_valid   = (state_q == S_ISSUE);
   assign bif.bus_op      = on_bus ? txn_op_q : 2'd0;
   assign bif.bus_addr    = on_bus ? txn_addr_q : '0;
   assign bif.bus_wdata   = on_bus ? txn_wdata_q : '0;
   assign bif.resp_valid  = in_resp;
   assign bif.resp_rdata  = in_resp ? rdata_q : '0;
   assign bif.resp_shared = in_resp && shared_q;
   assign bif.err         = in_resp && err_q;
endmodule
